// File: rtl/rca_pkg.sv
// Shared width default and a trace-friendly result record for the registered ripple-carry adder.
package rca_pkg;

    localparam int unsigned RCA_DEFAULT_W = 16;

    typedef struct packed {
        logic                     cout;
        logic [RCA_DEFAULT_W-1:0] sum;
    } rca_result_t;

endpackage

// File: rtl/ripple_carry_adder_reg_if.sv
// Operand/result bundle for ripple_carry_adder_reg; master drives operands, slave returns result.
interface ripple_carry_adder_reg_if
    import rca_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_W
);

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder; one link of the ripple carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/ripple_carry_adder_reg.sv
// N-bit ripple-carry adder built from chained full adders, with a registered {cout,sum}.
module ripple_carry_adder_reg
    import rca_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ripple_carry_adder_reg_if.slave     bus
);

    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic [N-1:0] r_sum;
    logic         r_cout;

    assign w_c[0] = bus.cin;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (w_c[i]),
            .s    (w_s[i]),
            .cout (w_c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[N];
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Checks N=4, N=16 and N=1 builds of ripple_carry_adder_reg against a plain-arithmetic model.
module tb_ripple_carry_adder_reg;

    logic clk;
    logic rst_n;

    ripple_carry_adder_reg_if #(.N(4))  bus4  ();
    ripple_carry_adder_reg_if #(.N(16)) bus16 ();
    ripple_carry_adder_reg_if #(.N(1))  bus1  ();

    ripple_carry_adder_reg #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    ripple_carry_adder_reg #(.N(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    ripple_carry_adder_reg #(.N(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact unsigned sum, wide enough to hold the carry.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
        return a + b + {31'd0, cin};
    endfunction

    function automatic logic [31:0] res16();
        return {15'd0, bus16.cout, bus16.sum};
    endfunction

    logic [16:0] exp_q[$];
    logic [16:0] e;
    logic [15:0] ra, rb;
    logic        rc;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } vec16_t;

    vec16_t dir16[4];

    initial begin
        rst_n = 1'b0;
        bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;
        bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus1.a = '0;  bus1.b = '0;  bus1.cin = 1'b0;

        // Drive inputs that would give nonzero results; reset must hold outputs at 0.
        bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b1;
        bus16.a = 16'h1234; bus16.b = 16'h0001; bus16.cin = 1'b1;
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sum4",   {28'd0, bus4.sum}, 32'd0);
        chk("rst_cout4",  {31'd0, bus4.cout}, 32'd0);
        chk("rst_sum16",  {16'd0, bus16.sum}, 32'd0);
        chk("rst_cout16", {31'd0, bus16.cout}, 32'd0);
        chk("rst_sum1",   {31'd0, bus1.sum}, 32'd0);
        chk("rst_cout1",  {31'd0, bus1.cout}, 32'd0);
        rst_n = 1'b1;
        chk("rel_hold16", res16(), 32'd0);

        // N=4 exhaustive, back-to-back, one-cycle latency.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = 1'(c);
                    @(negedge clk);
                    chk("exh4", {27'd0, bus4.cout, bus4.sum}, ref_add(32'(a), 32'(b), 1'(c)));
                end
            end
        end

        // Asynchronous reset mid-cycle with nonzero outputs.
        bus16.a = 16'h1234; bus16.b = 16'h0001; bus16.cin = 1'b0;
        @(negedge clk);
        chk("pre_rst16", res16(), 32'h1235);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst16", res16(), 32'd0);
        @(posedge clk);
        #1 chk("held_rst16", res16(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("released16", res16(), 32'd0);
        @(negedge clk);
        chk("first_cap16", res16(), 32'h1235);

        // N=16 directed boundaries.
        dir16[0] = '{16'hFFFF, 16'h0001, 1'b0};
        dir16[1] = '{16'hFFFF, 16'h0000, 1'b1};
        dir16[2] = '{16'hFFFF, 16'hFFFF, 1'b1};
        dir16[3] = '{16'h0000, 16'h0000, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus16.a = dir16[i].a; bus16.b = dir16[i].b; bus16.cin = dir16[i].cin;
            @(negedge clk);
            chk("dir16", res16(), ref_add(32'(dir16[i].a), 32'(dir16[i].b), dir16[i].cin));
        end

        // N=16 random, new operands every cycle; expectations queued one cycle behind.
        for (int i = 0; i < 10000; i++) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rand16", res16(), {15'd0, e});
            end
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            bus16.a = ra; bus16.b = rb; bus16.cin = rc;
            exp_q.push_back(17'(ref_add(32'(ra), 32'(rb), rc)));
            @(negedge clk);
        end
        e = exp_q.pop_front();
        chk("rand16_last", res16(), {15'd0, e});

        // N=1 build.
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        @(negedge clk);
        chk("n1_111", {30'd0, bus1.cout, bus1.sum}, 32'd3);
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
        @(negedge clk);
        chk("n1_100", {30'd0, bus1.cout, bus1.sum}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
